// File: rtl/seq_divider_24_if.sv
// Start/done handshake and operand/result bus of the sequential divider.
`timescale 1ns/1ps
interface seq_divider_24_if #(
  parameter int WIDTH = 24
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider_24.sv
// Radix-2 restoring divider, one quotient bit per clock, start/done handshake.
// Optional SIGNED_DIV_EN: two's-complement operands with sign fix-up on DONE.
`timescale 1ns/1ps
module seq_divider_24 #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_divider_24_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] r_q;
  logic             dbz_pend_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic             dbz_q;
`ifdef SIGNED_DIV_EN
  logic             neg_quo_q;
  logic             neg_rem_q;
`endif

  // Partial remainder stays below the divisor, so only the shifted value
  // needs the extra bit; its WIDTH+1-bit difference has a valid sign bit.
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;
  logic [WIDTH-1:0] res_quo;
  logic [WIDTH-1:0] res_rem;

  always_comb begin
    r_shift = {r_q, q_q[WIDTH-1]};
    trial   = r_shift - {1'b0, d_q};
`ifdef SIGNED_DIV_EN
    cap_a   = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    cap_b   = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
    res_quo = (neg_quo_q && !dbz_pend_q) ? -q_q : q_q;
    res_rem = (neg_rem_q && !dbz_pend_q) ? -r_q : r_q;
`else
    cap_a   = bus.dividend;
    cap_b   = bus.divisor;
    res_quo = q_q;
    res_rem = r_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      q_q        <= '0;
      d_q        <= '0;
      r_q        <= '0;
      dbz_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      quo_q      <= '0;
      rem_q      <= '0;
      dbz_q      <= 1'b0;
`ifdef SIGNED_DIV_EN
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            dbz_q  <= 1'b0;
            d_q    <= cap_b;
`ifdef SIGNED_DIV_EN
            neg_quo_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            neg_rem_q <= bus.dividend[WIDTH-1];
`endif
            if (bus.divisor == '0) begin
              // Zero divisor skips RUN; the raw dividend is the remainder.
              q_q        <= '1;
              r_q        <= bus.dividend;
              dbz_pend_q <= 1'b1;
              state_q    <= S_DONE;
            end else begin
              q_q        <= cap_a;
              r_q        <= '0;
              dbz_pend_q <= 1'b0;
              cnt_q      <= CNT_W'(WIDTH - 1);
              state_q    <= S_RUN;
            end
          end
        end
        S_RUN: begin
          q_q <= {q_q[WIDTH-2:0], ~trial[WIDTH]};
          r_q <= trial[WIDTH] ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
          if (cnt_q == '0) begin
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          quo_q   <= res_quo;
          rem_q   <= res_rem;
          dbz_q   <= dbz_pend_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_24.sv
// Self-checking bench for seq_divider_24: directed table, corner sequences, random vs model.
`timescale 1ns/1ps
module tb_seq_divider_24;
  localparam int W = 24;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  seq_divider_24_if #(.WIDTH(W)) bus ();

  seq_divider_24 #(.WIDTH(W), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dbz);
`ifdef SIGNED_DIV_EN
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    if (b == '0) begin
      q = '1; r = a; dbz = 1'b1;
    end else if (sa == -(1 << (W - 1)) && sb == -1) begin
      q = a; r = '0; dbz = 1'b0;
    end else begin
      q = W'(sa / sb); r = W'(sa % sb); dbz = 1'b0;
    end
`else
    if (b == '0) begin
      q = '1; r = a; dbz = 1'b1;
    end else begin
      q = a / b; r = a % b; dbz = 1'b0;
    end
`endif
  endfunction

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
    int n;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    tick();
    bus.start    = 1'b0;
    bus.dividend = W'($urandom);
    bus.divisor  = W'($urandom);
    check({name, ".busy_after_start"}, 32'(bus.busy), 32'd1);
    n = 0;
    while (bus.done !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check({name, ".latency"}, 32'(n), (b == '0) ? 32'd1 : 32'(W + 1));
    check({name, ".quotient"}, 32'(bus.quotient), 32'(eq));
    check({name, ".remainder"}, 32'(bus.remainder), 32'(er));
    check({name, ".div_by_zero"}, 32'(bus.div_by_zero), 32'(edbz));
    tick();
    check({name, ".done_one_cycle"}, 32'(bus.done), 32'd0);
    check({name, ".busy_after_done"}, 32'(bus.busy), 32'd0);
    check({name, ".quotient_held"}, 32'(bus.quotient), 32'(eq));
  endtask

  initial begin
    int n;
    int dones;
    logic [W-1:0] ra, rb, mq, mr;
    logic         mdbz;

    checks = 0;
    errors = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

`ifdef SIGNED_DIV_EN
    vecs.push_back('{"neg7_div_2",    24'hFFFFF9, 24'd2,      24'hFFFFFD, 24'hFFFFFF, 1'b0});
    vecs.push_back('{"minneg_div_m1", 24'h800000, 24'hFFFFFF, 24'h800000, 24'h000000, 1'b0});
    vecs.push_back('{"pos7_div_m2",   24'd7,      24'hFFFFFE, 24'hFFFFFD, 24'd1,      1'b0});
    vecs.push_back('{"neg7_div_m2",   24'hFFFFF9, 24'hFFFFFE, 24'd3,      24'hFFFFFF, 1'b0});
    vecs.push_back('{"div_zero",      24'h123456, 24'd0,      24'hFFFFFF, 24'h123456, 1'b1});
    vecs.push_back('{"after_zero",    24'd10,     24'd3,      24'd3,      24'd1,      1'b0});
    vecs.push_back('{"1000_div_7",    24'd1000,   24'd7,      24'd142,    24'd6,      1'b0});
`else
    vecs.push_back('{"1000_div_7",    24'd1000,   24'd7,      24'd142,    24'd6,      1'b0});
    vecs.push_back('{"msb_divisor",   24'hFFFFFF, 24'h800000, 24'd1,      24'h7FFFFF, 1'b0});
    vecs.push_back('{"div_zero",      24'h123456, 24'd0,      24'hFFFFFF, 24'h123456, 1'b1});
    vecs.push_back('{"after_zero",    24'd10,     24'd3,      24'd3,      24'd1,      1'b0});
    vecs.push_back('{"zero_dividend", 24'd0,      24'd5,      24'd0,      24'd0,      1'b0});
    vecs.push_back('{"small_by_max",  24'd5,      24'hFFFFFF, 24'd0,      24'd5,      1'b0});
    vecs.push_back('{"max_by_one",    24'hFFFFFF, 24'd1,      24'hFFFFFF, 24'd0,      1'b0});
`endif

    repeat (2) tick();
    check("reset.busy", 32'(bus.busy), 32'd0);
    check("reset.done", 32'(bus.done), 32'd0);
    check("reset.quotient", 32'(bus.quotient), 32'd0);
    check("reset.remainder", 32'(bus.remainder), 32'd0);
    check("reset.div_by_zero", 32'(bus.div_by_zero), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++)
      run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz);

    // start pulsed while busy must be ignored
    bus.start = 1'b1; bus.dividend = 24'd50; bus.divisor = 24'd5;
    tick();
    bus.start = 1'b0;
    n = 0;
    repeat (5) begin tick(); n++; end
    bus.start = 1'b1; bus.dividend = 24'd100; bus.divisor = 24'd9;
    tick(); n++;
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && n < 60) begin tick(); n++; end
    check("busy_start.latency", 32'(n), 32'(W + 1));
    check("busy_start.quotient", 32'(bus.quotient), 32'd10);
    check("busy_start.remainder", 32'(bus.remainder), 32'd0);
    dones = 0;
    repeat (40) begin tick(); if (bus.done === 1'b1) dones++; end
    check("busy_start.no_second_done", 32'(dones), 32'd0);

    // start held high: back-to-back with one idle cycle between
    bus.start = 1'b1; bus.dividend = 24'd20; bus.divisor = 24'd4;
    tick();
    n = 0;
    while (bus.done !== 1'b1 && n < 60) begin tick(); n++; end
    check("b2b.first_latency", 32'(n), 32'(W + 1));
    n = 0;
    do begin tick(); n++; end while (bus.done !== 1'b1 && n < 60);
    bus.start = 1'b0;
    check("b2b.done_spacing", 32'(n), 32'(W + 2));
    check("b2b.quotient", 32'(bus.quotient), 32'd5);
    tick();
    check("b2b.idle_after", 32'(bus.busy), 32'd0);

    // reset in the middle of a divide
    bus.start = 1'b1; bus.dividend = 24'd1000; bus.divisor = 24'd7;
    tick();
    bus.start = 1'b0;
    repeat (12) tick();
    rst_n = 1'b0;
    #1;
    check("midrst.busy", 32'(bus.busy), 32'd0);
    check("midrst.done", 32'(bus.done), 32'd0);
    check("midrst.quotient", 32'(bus.quotient), 32'd0);
    check("midrst.remainder", 32'(bus.remainder), 32'd0);
    check("midrst.div_by_zero", 32'(bus.div_by_zero), 32'd0);
    tick();
    rst_n = 1'b1;
    dones = 0;
    repeat (40) begin tick(); if (bus.done === 1'b1) dones++; end
    check("midrst.no_done", 32'(dones), 32'd0);
    run_op("post_rst_81_div_9", 24'd81, 24'd9, 24'd9, 24'd0, 1'b0);

    // random operands against the arithmetic model
    for (int i = 0; i < 150; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 9))
        0:       rb = '0;
        1, 2, 3: rb = W'($urandom_range(1, 255));
        4:       rb = '1;
        default: rb = W'($urandom);
      endcase
      if ($urandom_range(0, 19) == 0) ra = 24'h800000;
      model(ra, rb, mq, mr, mdbz);
      run_op($sformatf("rand%0d", i), ra, rb, mq, mr, mdbz);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
